// File: rtl/echo_processor_param_pkg.sv
// Shared encodings and constants for the parametrised echo processor.
package echo_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_MULTI  = 2'b10,
        MODE_MUTE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_CALC = 2'b10,
        ST_WR   = 2'b11
    } state_e;

    // Board switches count delay in groups of this many samples.
    localparam int unsigned DELAY_UNIT = 8;

endpackage

// File: rtl/echo_processor_param_if.sv
// Sample/control bundle between the ADC/DAC side, the switches and the echo core.
interface echo_processor_param_if #(
    parameter int unsigned DATA_W = 10
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [9:0]        delay_sel;
    logic [1:0]        mode;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              overrun;

    modport master (
        output data_in, data_valid, delay_sel, mode,
        input  data_out, out_valid, overrun
    );

    modport slave (
        input  data_in, data_valid, delay_sel, mode,
        output data_out, out_valid, overrun
    );
endinterface

// File: rtl/echo_delay_ram.sv
// Delay line storage: one write port, synchronous read with one cycle of latency, no reset.
module echo_delay_ram #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/echo_processor_param.sv
// Echo processor: per-sample IDLE/RD/CALC/WR sequence around a single delay RAM,
// with attenuated echo, saturation, warm-up masking and a sticky overrun flag.
module echo_processor_param
    import echo_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned OFFSET     = 512,
    parameter int unsigned GAIN_SHIFT = 1
) (
    input  logic                   sysclk,
    input  logic                   reset,
    echo_processor_param_if.slave  bus
);
    localparam int unsigned SUM_W    = DATA_W + 1;
    localparam int unsigned DEPTH_M1 = (2**ADDR_W) - 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(2**(DATA_W-1) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] x_q, x_d;
    logic [ADDR_W-1:0] dly_q, dly_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] y_q, y_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;

    logic                     edge_c;
    logic                     ram_we_c;
    logic [31:0]              dly_raw_c;
    logic [ADDR_W-1:0]        dly_clamp_c;
    logic [ADDR_W-1:0]        rd_addr_c;
    logic [DATA_W-1:0]        rd_data;
    logic signed [DATA_W-1:0] echo_c;
    logic signed [SUM_W-1:0]  sum_c;
    logic [DATA_W-1:0]        sat_c;

    echo_delay_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk   (sysclk),
        .we    (ram_we_c),
        .waddr (wr_ptr_q),
        .wdata (st_q),
        .raddr (rd_addr_c),
        .rdata (rd_data)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = bus.data_valid;
        x_d         = x_q;
        dly_d       = dly_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        y_d         = y_q;
        st_d        = st_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        ram_we_c    = 1'b0;

        edge_c      = bus.data_valid & ~valid_q;
        dly_raw_c   = 32'(bus.delay_sel) * DELAY_UNIT;
        dly_clamp_c = (dly_raw_c > DEPTH_M1) ? ADDR_W'(DEPTH_M1) : ADDR_W'(dly_raw_c);
        rd_addr_c   = wr_ptr_q - dly_clamp_c;

        // Stale RAM is hidden until enough samples have been written since reset.
        if ((dly_q == '0) || (fill_q < dly_q)) begin
            echo_c = '0;
        end else begin
            echo_c = $signed(rd_data) >>> GAIN_SHIFT;
        end
        sum_c = $signed({x_q[DATA_W-1], x_q}) + $signed({echo_c[DATA_W-1], echo_c});
        if (sum_c > SAT_MAX) begin
            sat_c = SAT_MAX[DATA_W-1:0];
        end else if (sum_c < SAT_MIN) begin
            sat_c = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_c = sum_c[DATA_W-1:0];
        end

        if (edge_c && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (edge_c) begin
                    x_d     = bus.data_in - DATA_W'(OFFSET);
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                dly_d   = dly_clamp_c;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                case (mode_e'(bus.mode))
                    MODE_BYPASS: begin y_d = x_q;   st_d = x_q;   end
                    MODE_SINGLE: begin y_d = sat_c; st_d = x_q;   end
                    MODE_MULTI:  begin y_d = sat_c; st_d = sat_c; end
                    default:     begin y_d = '0;    st_d = '0;    end
                endcase
                state_d = ST_WR;
            end
            ST_WR: begin
                ram_we_c    = 1'b1;
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
                if (fill_q != ADDR_W'(DEPTH_M1)) begin
                    fill_d = fill_q + ADDR_W'(1);
                end
                data_out_d  = y_q + DATA_W'(OFFSET);
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            x_q         <= '0;
            dly_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            y_q         <= '0;
            st_q        <= '0;
            data_out_q  <= DATA_W'(OFFSET);
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            x_q         <= x_d;
            dly_q       <= dly_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            y_q         <= y_d;
            st_q        <= st_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_echo_processor_param.sv
// Self-checking bench for echo_processor_param: vector table plus scoreboard of expected DAC samples.
module tb_echo_processor_param;

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        logic [9:0] dsel;
        int         din;
        int         exp;
    } vec_t;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    always #5 sysclk = ~sysclk;

    echo_processor_param_if #(.DATA_W(10)) bus ();

    echo_processor_param #(
        .DATA_W(10), .ADDR_W(13), .OFFSET(512), .GAIN_SHIFT(1)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int pulses = 0;
    int exp_q[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest outstanding expectation.
    always @(negedge sysclk) begin
        if (!reset && bus.out_valid === 1'b1) begin
            pulses++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got data_out=%0d, want no out_valid (t=%0t)",
                         bus.data_out, $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (bus.data_out !== 10'(e)) begin
                    n_bad++;
                    $display("FAIL sample: got data_out=%0d, want %0d (t=%0t)",
                             bus.data_out, e, $time);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge sysclk);
        reset          = 1'b1;
        bus.data_valid = 1'b0;
        repeat (n) @(posedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // One strobed sample; waits (bounded) until the scoreboard has consumed it.
    task automatic send(input int din, input int exp);
        bit done;
        @(negedge sysclk);
        bus.data_in    = 10'(din);
        bus.data_valid = 1'b1;
        exp_q.push_back(exp);
        @(negedge sysclk);
        bus.data_valid = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sysclk);
            #1;
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got no out_valid within 20 cycles, want data_out=%0d", exp);
            exp_q.delete();
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no completion by %0t, want $finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mult_exp[6];
        mult_exp = '{712, 612, 562, 537, 524, 518};

        // Vector table
        tbl.push_back('{1'b1, 2'b00, 10'd0, 1023, 1023});
        tbl.push_back('{1'b0, 2'b00, 10'd0, 0,    0   });
        tbl.push_back('{1'b0, 2'b00, 10'd3, 300,  300 });
        tbl.push_back('{1'b0, 2'b11, 10'd0, 900,  512 });
        for (int i = 0; i <= 16; i++)
            tbl.push_back('{i == 0, 2'b01, 10'd1, (i == 0) ? 712 : 512,
                            (i == 0) ? 712 : ((i == 8) ? 612 : 512)});
        for (int i = 0; i <= 40; i++)
            tbl.push_back('{i == 0, 2'b10, 10'd1, (i == 0) ? 712 : 512,
                            (i % 8 == 0) ? mult_exp[i / 8] : 512});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{i == 0, 2'b01, 10'd1, 912, (i < 8) ? 912 : 1023});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{i == 0, 2'b01, 10'd1, 0, 0});

        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.delay_sel  = '0;
        bus.mode       = 2'b00;

        // Reset values and first-sample latency
        do_reset(3);
        #1;
        chk("rst_data_out", 32'(bus.data_out), 512);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
        @(negedge sysclk);
        bus.data_in    = 10'd700;
        bus.data_valid = 1'b1;
        exp_q.push_back(700);
        for (int k = 0; k < 3; k++) begin
            @(posedge sysclk); #1;
            bus.data_valid = 1'b0;
            chk("lat_early_valid", 32'(bus.out_valid), 0);
        end
        @(posedge sysclk); #1;
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("lat_data", 32'(bus.data_out), 700);
        @(posedge sysclk); #1;
        chk("lat_pulse_end", 32'(bus.out_valid), 0);
        repeat (3) @(negedge sysclk);

        // Table-driven vectors
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(2);
            @(negedge sysclk);
            bus.mode      = tbl[i].mode;
            bus.delay_sel = tbl[i].dsel;
            send(tbl[i].din, tbl[i].exp);
        end

        // Overrun: second edge two cycles after the first
        do_reset(2);
        bus.mode = 2'b00;
        pulses   = 0;
        @(negedge sysclk);
        bus.data_in    = 10'd600;
        bus.data_valid = 1'b1;
        exp_q.push_back(600);
        @(negedge sysclk); bus.data_valid = 1'b0;
        @(negedge sysclk); bus.data_valid = 1'b1;
        @(negedge sysclk); bus.data_valid = 1'b0;
        repeat (10) @(negedge sysclk);
        #1;
        chk("ovr_pulses", 32'(pulses), 1);
        chk("ovr_flag", 32'(bus.overrun), 1);
        send(650, 650);
        chk("ovr_sticky", 32'(bus.overrun), 1);
        do_reset(2);
        #1;
        chk("ovr_cleared", 32'(bus.overrun), 0);

        // Reset mid-sample, with a new edge coinciding with reset
        pulses = 0;
        @(negedge sysclk);
        bus.data_in    = 10'd800;
        bus.data_valid = 1'b1;
        @(negedge sysclk); bus.data_valid = 1'b0;
        @(negedge sysclk); bus.data_valid = 1'b1; reset = 1'b1;
        @(negedge sysclk); bus.data_valid = 1'b0; reset = 1'b0;
        repeat (8) @(negedge sysclk);
        #1;
        chk("abort_pulses", 32'(pulses), 0);
        chk("abort_overrun", 32'(bus.overrun), 0);
        chk("abort_data_out", 32'(bus.data_out), 512);

        // Ramp across the write-pointer wrap, then a delay change mid-stream
        do_reset(2);
        bus.mode      = 2'b01;
        bus.delay_sel = 10'd1;
        for (int i = 0; i < 8200; i++)
            send(512 + (i % 64), (i < 8) ? 512 + (i % 64) : 512 + (i % 64) + ((i - 8) % 64) / 2);
        @(negedge sysclk);
        bus.delay_sel = 10'd2;
        for (int i = 8200; i < 8220; i++)
            send(512 + (i % 64), 512 + (i % 64) + ((i - 16) % 64) / 2);

        repeat (5) @(negedge sysclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
